adder_tree_csa_8_in: RTL and testbench



---
 rtl/adder_tree_csa_8_in_pkg.sv | 23 ++
 rtl/adder_tree_csa_8_in_csa_3_2.sv | 13 +
 rtl/adder_tree_csa_8_in.sv | 46 ++++
 tb/tb_adder_tree_csa_8_in.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/adder_tree_csa_8_in_pkg.sv
// adder_tree_pkg: stage counting, output width derivation and operand typedef for the CSA tree
package adder_tree_pkg;
  localparam int DEF_DATA_W = 3;
  localparam int DEF_DATA_N = 8;
  function automatic int stage_count(int i_num);
    int n;
    int c;
    n = i_num;
    c = 0;
    if (i_num == 4) c = 1;
    else if (i_num == 5) c = 2;
    else
      while (n > 4) begin
        n = n - n / 3;
        c++;
      end
    return c;
  endfunction
  function automatic int out_width(int w, int n);
    return w + stage_count(n) + 2;
  endfunction
  typedef logic [0:DEF_DATA_N-1][DEF_DATA_W-1:0] operand_arr_t;
endpackage

// File: rtl/adder_tree_csa_8_in_csa_3_2.sv
// csa_3_2: bitwise 3:2 compressor, carry pre-shifted left and truncated to W
module csa_3_2 #(
  parameter int W = 7
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);
  assign sum   = a ^ b ^ c;
  assign carry = {(a[W-2:0] & b[W-2:0]) | (a[W-2:0] & c[W-2:0]) | (b[W-2:0] & c[W-2:0]), 1'b0};
endmodule

// File: rtl/adder_tree_csa_8_in.sv
// adder_tree_csa_8_in: 4-rank pipelined carry-save tree summing eight unsigned words
module adder_tree_csa_8_in
  import adder_tree_pkg::*;
#(
  parameter int I_DATA_W = 3,
  parameter int I_DATA_N = 8,
  localparam int STAGES_N = stage_count(I_DATA_N) + 1,
  localparam int O_DATA_W = I_DATA_W + STAGES_N + 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [0:I_DATA_N-1][I_DATA_W-1:0]  i_data,
  output logic [O_DATA_W-1:0]                o_data
);
  if (I_DATA_N != 8) begin : g_bad_n
    $error("adder_tree_csa_8_in supports exactly 8 operands");
  end
  logic [I_DATA_N-1:0][O_DATA_W-1:0] ext;
  logic [5:0][O_DATA_W-1:0] l1, r1;
  logic [3:0][O_DATA_W-1:0] l2, r2;
  logic [1:0][O_DATA_W-1:0] l3, r3;
  logic [O_DATA_W-1:0] s3, c3;
  always_comb
    for (int i = 0; i < I_DATA_N; i++) ext[i] = O_DATA_W'(i_data[i]);
  csa_3_2 #(.W(O_DATA_W)) u_l1_0 (.a(ext[0]), .b(ext[1]), .c(ext[2]), .sum(l1[0]), .carry(l1[1]));
  csa_3_2 #(.W(O_DATA_W)) u_l1_1 (.a(ext[3]), .b(ext[4]), .c(ext[5]), .sum(l1[2]), .carry(l1[3]));
  assign l1[4] = ext[6];
  assign l1[5] = ext[7];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r1 <= '0;
    else r1 <= l1;
  csa_3_2 #(.W(O_DATA_W)) u_l2_0 (.a(r1[0]), .b(r1[1]), .c(r1[2]), .sum(l2[0]), .carry(l2[1]));
  csa_3_2 #(.W(O_DATA_W)) u_l2_1 (.a(r1[3]), .b(r1[4]), .c(r1[5]), .sum(l2[2]), .carry(l2[3]));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r2 <= '0;
    else r2 <= l2;
  // levels 3 and 4 share one rank: 4 -> 3 -> 2
  csa_3_2 #(.W(O_DATA_W)) u_l3 (.a(r2[0]), .b(r2[1]), .c(r2[2]), .sum(s3), .carry(c3));
  csa_3_2 #(.W(O_DATA_W)) u_l4 (.a(s3), .b(c3), .c(r2[3]), .sum(l3[0]), .carry(l3[1]));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r3 <= '0;
    else r3 <= l3;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) o_data <= '0;
    else o_data <= r3[0] + r3[1];
endmodule

// File: tb/tb_adder_tree_csa_8_in.sv
// tb_adder_tree_csa_8_in: randomized scoreboard bench for the 8-input CSA adder tree
module tb_adder_tree_csa_8_in;
  import adder_tree_pkg::*;
  localparam int OW = 7;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  operand_arr_t i_data = '0;
  logic [OW-1:0] o_data;
  int n_checks = 0;
  int n_fail = 0;

  adder_tree_csa_8_in dut (.clk(clk), .rst_n(rst_n), .i_data(i_data), .o_data(o_data));

  always #5 clk = ~clk;

  function automatic int ref_sum(operand_arr_t v);
    int s = 0;
    for (int i = 0; i < 8; i++) s += int'(v[i]);
    return s;
  endfunction

  task automatic test_reset();
    i_data = '1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (o_data !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: o_data=%0d expected 0", o_data);
    end
    rst_n = 1'b1;
    for (int e = 0; e < 4; e++) begin
      @(negedge clk);
      n_checks++;
      if (o_data !== OW'(e < 3 ? 0 : 56)) begin
        n_fail++;
        $display("FAIL reset_release edge%0d: o_data=%0d expected %0d", e, o_data, e < 3 ? 0 : 56);
      end
    end
  endtask

  task automatic test_max();
    i_data = '0;
    repeat (4) @(negedge clk);
    i_data = '1;
    for (int e = 0; e < 4; e++) begin
      @(negedge clk);
      n_checks++;
      if (o_data !== OW'(e < 3 ? 0 : 56)) begin
        n_fail++;
        $display("FAIL max_latency edge%0d: o_data=%0d expected %0d", e, o_data, e < 3 ? 0 : 56);
      end
    end
  endtask

  task automatic test_onehot();
    for (int k = 0; k < 8; k++) begin
      i_data = '0;
      i_data[k] = 3'd3;
      repeat (4) @(negedge clk);
      n_checks++;
      if (o_data !== OW'(3)) begin
        n_fail++;
        $display("FAIL onehot lane%0d: o_data=%0d expected 3", k, o_data);
      end
    end
  endtask

  task automatic test_zeros();
    i_data = '0;
    repeat (4) @(negedge clk);
    for (int c = 0; c < 8; c++) begin
      n_checks++;
      if (o_data !== '0) begin
        n_fail++;
        $display("FAIL zeros cycle%0d: o_data=%0d expected 0", c, o_data);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ramp_random();
    int q[$];
    int exp;
    for (int c = 0; c < 204; c++) begin
      if (q.size() == 4) begin
        exp = q.pop_front();
        n_checks++;
        if (o_data !== OW'(exp)) begin
          n_fail++;
          $display("FAIL stream cycle%0d: o_data=%0d expected %0d", c, o_data, exp);
        end
      end
      for (int i = 0; i < 8; i++) i_data[i] = (c == 0) ? 3'(i) : 3'($urandom_range(0, 7));
      q.push_back(ref_sum(i_data));
      @(negedge clk);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 8; i++) i_data[i] = (i % 2 == 0) ? 3'd7 : 3'd0;
    repeat (4) @(negedge clk);
    for (int c = 0; c < 64; c++) begin
      n_checks++;
      if (o_data !== OW'(28)) begin
        n_fail++;
        $display("FAIL hold cycle%0d: o_data=%0d expected 28", c, o_data);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midflight();
    i_data = '1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_data !== '0) begin
      n_fail++;
      $display("FAIL midflight_async: o_data=%0d expected 0", o_data);
    end
    i_data = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (o_data !== '0) begin
        n_fail++;
        $display("FAIL midflight_low cycle%0d: o_data=%0d expected 0", c, o_data);
      end
    end
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_checks++;
      if (o_data !== '0) begin
        n_fail++;
        $display("FAIL midflight_release cycle%0d: o_data=%0d expected 0", c, o_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_max();
    test_onehot();
    test_zeros();
    test_ramp_random();
    test_hold();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
